// File: rtl/sdram_byte_bridge.sv
// sdram_byte_bridge: 8-bit CPU bus to 16-bit toggle-handshake SDRAM port.
// Tracks acks, selects the read byte lane, keeps a one-entry pending slot and
// an optional last-word read-hit buffer. A request times out if no ack arrives.
module sdram_byte_bridge #(
    parameter int          ADDR_W  = 16,
    parameter bit          HIT_EN  = 1'b1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              bus_cs,
    input  logic              bus_oe,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_d,
    output logic [7:0]        bus_q,
    output logic              busy,
    output logic              overflow,
    output logic              timeout_err,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        mem_ds,
    output logic              mem_we,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]        state;
    logic              prev_rd, prev_wr, ack_prev;
    logic [ADDR_W-1:0] prev_addr;
    logic [31:0]       tcnt;

    logic [15:0]       hit_word;
    logic [ADDR_W-2:0] hit_tag;
    logic              hit_valid;

    logic              pend_valid, pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [7:0]        pend_d;

    logic              rd_evt, wr_evt, ev_valid, ack_evt, ev_hit;
    logic              sl_valid, sl_we, sl_hit, issue;
    logic [ADDR_W-1:0] sl_addr, iss_addr;
    logic [7:0]        sl_d, iss_d;
    logic              iss_we;
    logic [15:0]       nh_word;
    logic [ADDR_W-2:0] nh_tag;
    logic              nh_valid;

    function automatic logic [7:0] sel_byte(input logic [15:0] w, input logic hi);
        return hi ? w[15:8] : w[7:0];
    endfunction

    assign busy = (state == WAIT);

    // Event detection, hit-buffer update on completion, slot capture and issue decision.
    always_comb begin
        rd_evt   = bus_cs & bus_oe & (!prev_rd | (bus_addr != prev_addr));
        wr_evt   = bus_cs & bus_we & !prev_wr;
        ev_valid = rd_evt | wr_evt;
        ack_evt  = mem_ack ^ ack_prev;
        ev_hit   = HIT_EN && !wr_evt && hit_valid && (bus_addr[ADDR_W-1:1] == hit_tag);

        nh_word  = hit_word;
        nh_tag   = hit_tag;
        nh_valid = hit_valid;
        if (state == WAIT && ack_evt) begin
            if (!mem_we) begin
                nh_word  = mem_q;
                nh_tag   = mem_a[ADDR_W-1:1];
                nh_valid = 1'b1;
            end else if (hit_valid && mem_a[ADDR_W-1:1] == hit_tag) begin
                if (mem_a[0]) nh_word[15:8] = mem_d[7:0];
                else          nh_word[7:0]  = mem_d[7:0];
            end
        end

        // A same-cycle event lands in the slot before the drain looks at it.
        sl_valid = pend_valid | ev_valid;
        sl_we    = ev_valid ? wr_evt   : pend_we;
        sl_addr  = ev_valid ? bus_addr : pend_addr;
        sl_d     = ev_valid ? bus_d    : pend_d;
        sl_hit   = HIT_EN && !sl_we && nh_valid && (sl_addr[ADDR_W-1:1] == nh_tag);

        iss_we   = (state == IDLE) ? wr_evt   : sl_we;
        iss_addr = (state == IDLE) ? bus_addr : sl_addr;
        iss_d    = (state == IDLE) ? bus_d    : sl_d;
        issue    = ((state == IDLE) && ev_valid && !ev_hit) ||
                   ((state == WAIT) && ack_evt && sl_valid && !sl_hit);
    end

    // Request state machine, pending slot, hit buffer and sticky error flags.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state       <= IDLE;
            prev_rd     <= 1'b0;
            prev_wr     <= 1'b0;
            prev_addr   <= '0;
            ack_prev    <= mem_ack;
            tcnt        <= '0;
            hit_word    <= '0;
            hit_tag     <= '0;
            hit_valid   <= 1'b0;
            pend_valid  <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_d      <= '0;
            bus_q       <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            mem_req     <= 1'b0;
            mem_a       <= '0;
            mem_ds      <= '0;
            mem_we      <= 1'b0;
            mem_d       <= '0;
        end else begin
            prev_rd   <= bus_cs & bus_oe;
            prev_wr   <= bus_cs & bus_we;
            prev_addr <= bus_addr;
            ack_prev  <= mem_ack;
            hit_word  <= nh_word;
            hit_tag   <= nh_tag;
            hit_valid <= nh_valid;

            case (state)
                IDLE: begin
                    if (ev_valid && ev_hit)
                        bus_q <= sel_byte(hit_word, bus_addr[0]);
                end
                default: begin
                    if (ev_valid && pend_valid)
                        overflow <= 1'b1;
                    if (ack_evt) begin
                        if (!mem_we)
                            bus_q <= sel_byte(mem_q, mem_a[0]);
                        pend_valid <= 1'b0;
                        state      <= IDLE;
                        if (sl_valid && sl_hit)
                            bus_q <= sel_byte(nh_word, sl_addr[0]);
                    end else if (TIMEOUT != 0 && (tcnt + 32'd1) == TIMEOUT) begin
                        timeout_err <= 1'b1;
                        pend_valid  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                        if (ev_valid) begin
                            pend_valid <= 1'b1;
                            pend_we    <= wr_evt;
                            pend_addr  <= bus_addr;
                            pend_d     <= bus_d;
                        end
                    end
                end
            endcase

            if (issue) begin
                mem_req <= ~mem_req;
                mem_a   <= iss_addr;
                mem_we  <= iss_we;
                mem_ds  <= iss_we ? (iss_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                if (iss_we) mem_d <= {iss_d, iss_d};
                tcnt    <= '0;
                state   <= WAIT;
            end
        end
    end

endmodule

// File: tb/tb_sdram_byte_bridge.sv
// Directed bench for sdram_byte_bridge: miss, hit, coherence, pending/overflow,
// timeout, simultaneous read/write and reset mid-request.
module tb_sdram_byte_bridge;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        bus_cs, bus_oe, bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_d;
    logic [15:0] mem_q;
    logic        ack, ack0;

    logic [7:0]  bus_q, bus_q0;
    logic        busy, overflow, timeout_err, mem_req, mem_we;
    logic [15:0] mem_a, mem_d;
    logic [1:0]  mem_ds;
    logic        busy0, overflow0, timeout_err0, mem_req0, mem_we0;
    logic [15:0] mem_a0, mem_d0;
    logic [1:0]  mem_ds0;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    sdram_byte_bridge #(.ADDR_W(16), .HIT_EN(1'b1), .TIMEOUT(8)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .bus_cs(bus_cs), .bus_oe(bus_oe), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_d(bus_d), .bus_q(bus_q),
        .busy(busy), .overflow(overflow), .timeout_err(timeout_err),
        .mem_req(mem_req), .mem_ack(ack), .mem_a(mem_a), .mem_ds(mem_ds),
        .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
    );

    // Hit buffer disabled: every read must go to SDRAM.
    sdram_byte_bridge #(.ADDR_W(16), .HIT_EN(1'b0), .TIMEOUT(8)) dut_nohit (
        .clk_sys(clk_sys), .reset(reset),
        .bus_cs(bus_cs), .bus_oe(bus_oe), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_d(bus_d), .bus_q(bus_q0),
        .busy(busy0), .overflow(overflow0), .timeout_err(timeout_err0),
        .mem_req(mem_req0), .mem_ack(ack0), .mem_a(mem_a0), .mem_ds(mem_ds0),
        .mem_we(mem_we0), .mem_d(mem_d0), .mem_q(mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset = 1'b1; bus_cs = 0; bus_oe = 0; bus_we = 0;
        bus_addr = '0; bus_d = '0; mem_q = '0; ack = 0; ack0 = 0;
        step(); step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_ds", mem_ds, 0);
        chk("rst_bus_q", bus_q, 0);
        chk("rst_flags", {busy, overflow, timeout_err, mem_we}, 0);
        reset = 1'b0;
        step();

        // Read miss at 1235, ack after 5 cycles with BEEF.
        bus_cs = 1; bus_oe = 1; bus_addr = 16'h1235;
        step();
        chk("miss_req", mem_req, 1);
        chk("miss_ds", mem_ds, 2'b11);
        chk("miss_a", mem_a, 16'h1235);
        chk("miss_we", mem_we, 0);
        for (int i = 0; i < 4; i++) step();
        chk("miss_busy4", busy, 1);
        mem_q = 16'hBEEF; ack = ~ack; ack0 = ~ack0;
        step();
        chk("miss_bus_q", bus_q, 8'hBE);
        chk("miss_busy_done", busy, 0);
        chk("miss_req_once", mem_req, 1);

        // Read hit on the low byte of the same word.
        bus_addr = 16'h1234;
        step();
        chk("hit_bus_q", bus_q, 8'hEF);
        chk("hit_no_req", mem_req, 1);
        chk("hit_busy", busy, 0);
        chk("nohit_req", mem_req0, 0);
        chk("nohit_busy", busy0, 1);
        ack0 = ~ack0;
        bus_oe = 0;
        step();

        // Write 55 to 1234, then read back from the buffer.
        bus_we = 1; bus_d = 8'h55;
        step();
        chk("wr_req", mem_req, 0);
        chk("wr_we", mem_we, 1);
        chk("wr_ds", mem_ds, 2'b01);
        chk("wr_d", mem_d, 16'h5555);
        bus_we = 0; ack = ~ack;
        step();
        chk("wr_done", busy, 0);
        bus_oe = 1;
        step();
        chk("coh_bus_q", bus_q, 8'h55);
        chk("coh_no_req", mem_req, 0);
        bus_addr = 16'h1235;
        step();
        chk("coh_hi_bus_q", bus_q, 8'hBE);
        chk("coh_hi_no_req", mem_req, 0);
        bus_oe = 0;
        step();

        // Read miss at 2000; two writes land in the pending slot meanwhile.
        bus_oe = 1; bus_addr = 16'h2000;
        step();
        chk("pend_req1", mem_req, 1);
        bus_oe = 0; bus_we = 1; bus_addr = 16'h3000; bus_d = 8'h11;
        step();
        chk("pend_a_no_ovf", overflow, 0);
        bus_we = 0;
        step();
        bus_we = 1; bus_addr = 16'h3001; bus_d = 8'h22;
        step();
        chk("pend_ovf", overflow, 1);
        chk("pend_still_req1", mem_req, 1);
        bus_we = 0;
        step();
        mem_q = 16'h1234; ack = ~ack;
        step();
        chk("pend_rd_bus_q", bus_q, 8'h34);
        chk("pend_drain_req", mem_req, 0);
        chk("pend_drain_a", mem_a, 16'h3001);
        chk("pend_drain_ds", mem_ds, 2'b10);
        chk("pend_drain_d", mem_d, 16'h2222);
        chk("pend_drain_busy", busy, 1);
        ack = ~ack;
        step();
        chk("pend_done", busy, 0);
        chk("pend_two_toggles", mem_req, 0);

        // Timeout after 8 WAIT cycles with no ack.
        bus_oe = 1; bus_addr = 16'h4000;
        step();
        chk("to_req", mem_req, 1);
        for (int i = 0; i < 7; i++) step();
        chk("to_busy7", {busy, timeout_err}, 2'b10);
        step();
        chk("to_err", timeout_err, 1);
        chk("to_busy_clr", busy, 0);
        mem_q = 16'h9999; ack = ~ack;
        step();
        chk("to_late_ack_bus_q", bus_q, 8'h34);
        chk("to_late_ack_idle", {busy, mem_req}, 2'b01);
        bus_addr = 16'h4002;
        step();
        chk("to_next_req", mem_req, 0);
        mem_q = 16'hABCD; ack = ~ack;
        step();
        chk("to_next_bus_q", bus_q, 8'hCD);
        chk("to_next_idle", busy, 0);
        bus_oe = 0;
        step();

        // oe and we rise together: a single write only.
        bus_oe = 1; bus_we = 1; bus_addr = 16'h5001; bus_d = 8'h77;
        step();
        chk("sim_req", mem_req, 1);
        chk("sim_we", mem_we, 1);
        chk("sim_ds", mem_ds, 2'b10);
        step();
        chk("sim_single", {mem_req, busy}, 2'b11);

        // Reset while waiting, then a stray ack.
        reset = 1'b1;
        step();
        chk("rst2_outs", {mem_req, mem_we, mem_ds, busy, overflow, timeout_err}, 0);
        chk("rst2_a_d", {mem_a, mem_d, bus_q}, 0);
        reset = 1'b0; bus_oe = 0; bus_we = 0;
        step();
        ack = ~ack; mem_q = 16'h5A5A;
        step();
        chk("rst2_stray_bus_q", bus_q, 0);
        chk("rst2_stray_idle", {busy, mem_req}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_byte_bridge.md
Name: sdram_byte_bridge

Overview:
- Parametrised successor to the top-level CPU-RAM-to-SDRAM request logic.
- Converts an 8-bit CPU bus (chip select, output enable, write enable) into toggle-handshake requests on one 16-bit SDRAM port.
- Adds the following:
  - ack tracking
  - byte-lane read selection
  - a one-entry pending slot
  - an optional last-word read-hit buffer
  - a request timeout
- Sits between the machine core (ram_* bus) and an sdram port (portN_*); all logic runs on the SDRAM clock.

Parameters:
- ADDR_W, 16, byte address width; the word address is bus_addr[ADDR_W-1:1].
- HIT_EN, 1, 1 enables the last-word read-hit buffer; 0 sends every read to SDRAM.
- TIMEOUT, 255, number of WAIT cycles before a request is abandoned; 0 disables the timeout.

Ports:
- clk_sys  in  1  system/SDRAM clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_cs  in  1  chip select.
- bus_oe  in  1  read enable.
- bus_we  in  1  write enable.
- bus_addr  in  ADDR_W  byte address.
- bus_d  in  8  write data.
- bus_q  out  8  read data, held until the next read completes.
- busy  out  1  a request is outstanding (state WAIT).
- overflow  out  1  sticky; set when a pending event is overwritten.
- timeout_err  out  1  sticky; set when a request is abandoned.
- mem_req  out  1  request toggle.
- mem_ack  in  1  ack toggle; a change marks completion.
- mem_a  out  ADDR_W  request byte address.
- mem_ds  out  2  byte strobes: {hi,lo}.
- mem_we  out  1  1 = write.
- mem_d  out  16  write data.
- mem_q  in  16  read word.

Behaviour:
- Event detection, with registered prev_rd, prev_wr and prev_addr updated every cycle:
  - rd_evt = cs&oe&(!prev_rd | addr!=prev_addr).
  - wr_evt = cs&we&!prev_wr.
  - If both occur in the same cycle, the write is taken and the read is discarded (overflow is not set).
- Ack detection: ack_prev <= mem_ack every cycle in all states; ack_evt = mem_ack^ack_prev.
- Issuing a request (from IDLE, or from WAIT when draining the pending slot):
  - mem_req toggles; mem_a = addr.
  - Write: mem_we=1, mem_ds = addr[0]?2'b10:2'b01, mem_d = {d,d}.
  - Read: mem_we=0, mem_ds=2'b11.
  - Next state is WAIT; a timeout counter loads 0.
- IDLE state:
  - A read event that hits (HIT_EN & hit_valid & addr[ADDR_W-1:1]==hit_tag) sets bus_q on the next edge: the byte selected by addr[0] (1 = [15:8]) from hit_word. No request is issued and the state stays IDLE.
  - Any other event issues a request.
  - ack_evt in IDLE (a late ack) is absorbed with no effect.
- WAIT state:
  - On ack_evt, a read does the following:
    - bus_q <= addr[0] ? mem_q[15:8] : mem_q[7:0].
    - hit_word <= mem_q, hit_tag <= word address, hit_valid <= 1.
  - On ack_evt, a write whose word address matches hit_tag updates that byte of hit_word (write-through coherence).
  - After completion, a valid pending slot is issued on the same edge (WAIT->WAIT) and the slot is cleared; otherwise the state returns to IDLE.
  - A pending read that would hit is served from the buffer at drain time, without issuing a request, and the state returns to IDLE.
- Events arriving during WAIT are stored in a one-entry slot (type, addr, data).
  - If the slot is already valid, the new event overwrites it and overflow <= 1.
  - An event in the same cycle as ack_evt goes into the slot before the drain, so it is issued immediately.
- Timeout:
  - With TIMEOUT≠0, the counter increments each WAIT cycle without ack.
  - When the count equals TIMEOUT: timeout_err <= 1, the request is dropped, the pending slot is cleared, and the state returns to IDLE.
  - A later stray ack is absorbed.
- busy = (state==WAIT), registered.
- Latency:
  - Hit: bus_q valid 1 cycle after the event cycle.
  - Miss: bus_q valid 1 cycle after the ack_evt cycle.
  - mem_* outputs change 1 cycle after the event cycle.
- Reset:
  - mem_req=0, mem_we=0, mem_ds=0, mem_a=0, mem_d=0.
  - bus_q=0, busy=0, overflow=0, timeout_err=0.
  - hit_valid=0, pending cleared, state IDLE, ack_prev <= mem_ack.
  - Reset mid-WAIT abandons the request; a subsequent ack is absorbed.
- Address arithmetic: no wrap-around handling is needed; addresses pass through unmodified.

Test Plan:
- Read miss: cs=oe=1, addr=16'h1235; SDRAM model acks after 5 cycles with mem_q=16'hBEEF -> mem_req toggles once, mem_ds=11, busy for 5 cycles, bus_q=8'hBE one cycle after ack.
- Read hit: after the previous case, addr changes to 16'h1234 with oe held -> no mem_req toggle, bus_q=8'hEF next cycle. Same case with HIT_EN=0 -> a request is issued.
- Write coherence: write 8'h55 to 16'h1234 (mem_ds=01, mem_d=16'h5555), ack, then read 16'h1234 -> hit returns 8'h55 with no request.
- Pending/overflow: during a WAIT, issue write A then write B -> overflow=1; after ack only B is issued (exactly two mem_req toggles total).
- Timeout: TIMEOUT=8 and no ack -> timeout_err=1 after 8 WAIT cycles, busy=0. A late ack toggle is ignored, and the next read completes on its own ack.
- Simultaneous/reset: oe and we rise together -> a single write request only. Asserting reset mid-WAIT -> all outputs return to reset values, and the following ack produces no bus_q change.
